// File: rtl/switchbox_pkg.sv
// rtl/switchbox_pkg.sv - shared constants, state type and pin-ownership helper for the switch box loader
package switchbox_pkg;

  localparam int N_TB    = 5;
  localparam int N_LR    = 4;
  localparam int W       = 6;
  localparam int N_WORDS = 2 * N_TB + 2 * N_LR;
  localparam int NBITS   = N_WORDS * W;

  localparam logic [2:0] SIDE_OFF    = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SIDE  = 2'd1;
  localparam logic [1:0] ERR_INDEX = 2'd2;
  localparam logic [1:0] ERR_LOOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_COMMIT
  } state_e;

  typedef struct packed {
    logic [2:0] side;
    logic [2:0] idx;
  } pin_id_t;

  // Word order is top, bottom, left, right; returns the pin a word drives.
  function automatic pin_id_t word_owner(input int k, input int n_tb, input int n_lr);
    pin_id_t o;
    if (k < n_tb) begin
      o.side = SIDE_TOP;
      o.idx  = 3'(k);
    end else if (k < 2 * n_tb) begin
      o.side = SIDE_BOTTOM;
      o.idx  = 3'(k - n_tb);
    end else if (k < 2 * n_tb + n_lr) begin
      o.side = SIDE_LEFT;
      o.idx  = 3'(k - 2 * n_tb);
    end else begin
      o.side = SIDE_RIGHT;
      o.idx  = 3'(k - 2 * n_tb - n_lr);
    end
    return o;
  endfunction

endpackage

// File: rtl/switchbox_cfg_check.sv
// rtl/switchbox_cfg_check.sv - combinational legality check of one select word
module switchbox_cfg_check
  import switchbox_pkg::*;
#(
  parameter int N_TB = 5,
  parameter int N_LR = 4,
  parameter int W    = 6
) (
  input  logic [W-1:0] word_i,
  input  logic [2:0]   own_side_i,
  input  logic [2:0]   own_idx_i,
  output logic         fault_o,
  output logic [1:0]   code_o
);

  logic [2:0]   side;
  logic [W-4:0] idx;
  logic [1:0]   code_d;

  assign side = word_i[2:0];
  assign idx  = word_i[W-1:3];

  // Side is judged before index, index before self-loop; an off pin ignores its index.
  always_comb begin
    code_d = ERR_NONE;
    case (side)
      SIDE_OFF: code_d = ERR_NONE;
      SIDE_TOP, SIDE_BOTTOM: if (int'(idx) >= N_TB) code_d = ERR_INDEX;
      SIDE_RIGHT, SIDE_LEFT: if (int'(idx) >= N_LR) code_d = ERR_INDEX;
      default: code_d = ERR_SIDE;
    endcase
    if (code_d == ERR_NONE && side != SIDE_OFF && side == own_side_i && idx == own_idx_i)
      code_d = ERR_LOOP;
  end

  assign code_o  = code_d;
  assign fault_o = (code_d != ERR_NONE);

endmodule

// File: rtl/switchbox_cfg_loader.sv
// rtl/switchbox_cfg_loader.sv - serial bitstream loader with word checking and atomic commit
module switchbox_cfg_loader
  import switchbox_pkg::*;
#(
  parameter  int N_TB    = 5,
  parameter  int N_LR    = 4,
  parameter  int W       = 6,
  localparam int N_WORDS = 2 * N_TB + 2 * N_LR,
  localparam int NBITS   = N_WORDS * W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             cfg_bit,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [NBITS-1:0] cfg_active,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [4:0]       err_idx,
  output logic [1:0]       err_code
);

  localparam int CNT_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(NBITS - 1);
  localparam logic [4:0]       LAST_WORD = 5'(N_WORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       k_q, k_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [NBITS-1:0] active_q, active_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [4:0]       err_idx_q, err_idx_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [W-1:0] cur_word;
  pin_id_t      owner;
  logic         chk_fault;
  logic [1:0]   chk_code;

  assign cur_word = shadow_q[int'(k_q) * W +: W];
  assign owner    = word_owner(int'(k_q), N_TB, N_LR);

  switchbox_cfg_check #(
    .N_TB(N_TB),
    .N_LR(N_LR),
    .W   (W)
  ) u_check (
    .word_i    (cur_word),
    .own_side_i(owner.side),
    .own_idx_i (owner.idx),
    .fault_o   (chk_fault),
    .code_o    (chk_code)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SHIFT;
          cnt_d      = '0;
          k_d        = '0;
          err_d      = 1'b0;
          err_idx_d  = '0;
          err_code_d = ERR_NONE;
        end else if (clear) begin
          active_d = '0;
          err_d    = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cfg_valid) begin
          shadow_d[cnt_q] = cfg_bit;
          cnt_d           = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = ST_CHECK;
            k_d     = '0;
          end
        end
      end
      ST_CHECK: begin
        if (chk_fault) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          err_idx_d  = k_q;
          err_code_d = chk_code;
        end else if (k_q == LAST_WORD) begin
          state_d = ST_COMMIT;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      ST_COMMIT: begin
        active_d = shadow_q;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      err_code_q <= err_code_d;
    end
  end

  assign cfg_ready  = (state_q == ST_SHIFT);
  assign busy       = (state_q != ST_IDLE);
  assign cfg_active = active_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_idx    = err_idx_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// tb/tb_switchbox_cfg_loader.sv - self-checking bench for the switch box configuration loader
module tb_switchbox_cfg_loader;

  localparam int NW = 18;
  localparam int NB = 108;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          cfg_bit = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [NB-1:0] cfg_active;
  logic          busy;
  logic          done;
  logic          err;
  logic [4:0]    err_idx;
  logic [1:0]    err_code;

  logic [5:0] words [NW];
  logic [5:0] model_active [NW];
  int checks = 0;
  int errors = 0;

  switchbox_cfg_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_active(cfg_active),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_idx   (err_idx),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word k drives top k, bottom k-5, left k-10, right k-14.
  function automatic int own_side(input int k);
    if (k < 5) return 1;
    if (k < 10) return 3;
    if (k < 14) return 4;
    return 2;
  endfunction

  function automatic int own_idx(input int k);
    if (k < 5) return k;
    if (k < 10) return k - 5;
    if (k < 14) return k - 10;
    return k - 14;
  endfunction

  function automatic int word_code(input int k, input logic [5:0] w);
    int s;
    int ix;
    s  = int'(w[2:0]);
    ix = int'(w[5:3]);
    if (s == 0) return 0;
    if (s > 4) return 1;
    if ((s == 1 || s == 3) && ix > 4) return 2;
    if ((s == 2 || s == 4) && ix > 3) return 2;
    if (s == own_side(k) && ix == own_idx(k)) return 3;
    return 0;
  endfunction

  function automatic logic [NB-1:0] pack_model();
    logic [NB-1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[k*6 +: 6] = model_active[k];
    return v;
  endfunction

  function automatic logic [5:0] legal_word(input int k);
    int s;
    int ix;
    do begin
      s = $urandom_range(0, 4);
      if (s == 0) ix = $urandom_range(0, 7);
      else if (s == 1 || s == 3) ix = $urandom_range(0, 4);
      else ix = $urandom_range(0, 3);
    end while (s != 0 && s == own_side(k) && ix == own_idx(k));
    return {3'(ix), 3'(s)};
  endfunction

  function automatic logic [5:0] illegal_word(input int k);
    int kind;
    kind = $urandom_range(1, 3);
    if (kind == 1) return {3'($urandom_range(0, 7)), 3'($urandom_range(5, 7))};
    if (kind == 2) begin
      if ($urandom_range(0, 1) == 0) return {3'($urandom_range(5, 7)), ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd3};
      return {3'($urandom_range(4, 7)), ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd4};
    end
    return {3'(own_idx(k)), 3'(own_side(k))};
  endfunction

  task automatic do_load(input string tag, input bit stall, input bit noise, input bit with_clear);
    int fk;
    int fc;
    int i;
    int guard;
    int exp_idle;
    int done_at;
    int err_at;
    int idle_at;
    int done_cnt;
    logic ready_c1;
    bit v;
    fk = -1;
    fc = 0;
    for (int k = 0; k < NW; k++) begin
      if (fk < 0 && word_code(k, words[k]) != 0) begin
        fk = k;
        fc = word_code(k, words[k]);
      end
    end
    start = 1'b1;
    clear = with_clear;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check({tag, " ready_after_start"}, cfg_ready, 1);
    check({tag, " err_cleared_by_start"}, err, 0);
    i = 0;
    guard = 0;
    while (i < NB && guard < 2000) begin
      v = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      cfg_valid = v;
      cfg_bit = words[i / 6][i % 6];
      if (noise) begin
        start = ($urandom_range(0, 3) == 0);
        clear = ($urandom_range(0, 3) == 0);
      end
      tick();
      guard++;
      if (v) i++;
    end
    cfg_valid = 1'b0;
    cfg_bit = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    check({tag, " bits_shifted"}, i, NB);
    exp_idle = (fk < 0) ? 19 : fk + 1;
    done_at = -1;
    err_at = -1;
    idle_at = -1;
    done_cnt = 0;
    ready_c1 = 1'bx;
    for (int n = 1; n <= 24; n++) begin
      if (noise && n <= exp_idle) begin
        start = ($urandom_range(0, 2) == 0);
        clear = ($urandom_range(0, 2) == 0);
      end else begin
        start = 1'b0;
        clear = 1'b0;
      end
      tick();
      if (n == 1) ready_c1 = cfg_ready;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (err === 1'b1 && err_at < 0) err_at = n;
      if (busy === 1'b0 && idle_at < 0) idle_at = n;
    end
    start = 1'b0;
    clear = 1'b0;
    check({tag, " ready_low_in_check"}, ready_c1, 0);
    check({tag, " idle_cycle"}, idle_at, exp_idle);
    if (fk < 0) begin
      for (int k = 0; k < NW; k++) model_active[k] = words[k];
      check({tag, " done_cycle"}, done_at, 19);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " no_err"}, err_at, -1);
    end else begin
      check({tag, " err_cycle"}, err_at, fk + 1);
      check({tag, " no_done"}, done_cnt, 0);
      check({tag, " err_idx"}, err_idx, fk);
      check({tag, " err_code"}, err_code, fc);
    end
    check({tag, " cfg_active"}, cfg_active, pack_model());
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < NW; k++) model_active[k] = '0;
    check("clear cfg_active", cfg_active, 0);
    check("clear err", err, 0);
  endtask

  task automatic all_legal();
    for (int k = 0; k < NW; k++) words[k] = legal_word(k);
  endtask

  initial begin
    for (int k = 0; k < NW; k++) begin
      words[k] = '0;
      model_active[k] = '0;
    end
    tick();
    tick();
    check("reset cfg_ready", cfg_ready, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset err_idx", err_idx, 0);
    check("reset err_code", err_code, 0);
    check("reset cfg_active", cfg_active, 0);
    rst_n = 1'b1;
    tick();

    do_load("zeros", 1'b0, 1'b0, 1'b0);

    words[5] = 6'b011_010;
    words[14] = 6'b000_001;
    do_load("directed", 1'b0, 1'b0, 1'b0);
    check("directed bottom0", cfg_active[35:30], 6'b011010);
    check("directed right0", cfg_active[89:84], 6'b000001);

    for (int k = 0; k < NW; k++) words[k] = '0;
    words[3] = 6'b000_110;
    do_load("bad_side", 1'b0, 1'b0, 1'b0);

    words[3] = '0;
    words[12] = 6'b100_010;
    do_load("bad_index", 1'b0, 1'b0, 1'b0);

    words[12] = '0;
    words[2] = 6'b010_001;
    do_load("self_loop", 1'b0, 1'b0, 1'b0);

    do_clear();

    all_legal();
    do_load("start_beats_clear", 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      all_legal();
      if (r % 2 == 1) begin
        int fk;
        fk = $urandom_range(0, NW - 1);
        words[fk] = illegal_word(fk);
      end
      do_load($sformatf("random%0d", r), 1'b1, 1'b1, 1'b0);
    end

    all_legal();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cfg_valid = 1'b1;
      cfg_bit = words[i / 6][i % 6];
      tick();
    end
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midload_reset busy", busy, 0);
    check("midload_reset cfg_ready", cfg_ready, 0);
    check("midload_reset cfg_active", cfg_active, 0);
    for (int k = 0; k < NW; k++) model_active[k] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("after_reset busy", busy, 0);

    all_legal();
    do_load("fresh", 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switchbox_cfg_loader.md
# switchbox_cfg_loader

Serial configuration loader and sequencer for the 6×8 routing switch box (5 top/bottom pins, 4 left/right pins, one 6-bit select word per pin). It shifts in a complete bitstream of 18 select words, checks every word for legality, and commits the whole set to the switch box atomically. If any word is illegal, the active configuration is left unchanged and the first fault is reported.

## Interface
- `N_TB`, default 5: pins per top/bottom side.
- `N_LR`, default 4: pins per left/right side.
- `W`, default 6: select word width; bits [2:0] are the side code (0 off, 1 top, 2 right, 3 bottom, 4 left), bits [5:3] are the source index.
- Derived, not overridable: `N_WORDS` = 2·N_TB + 2·N_LR = 18. `NBITS` = N_WORDS·W = 108.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a load; honoured only in IDLE.
- `clear`  in  1  in IDLE, sets all active words to 0 (all pins high-Z).
- `cfg_bit`  in  1  serial data, LSB of word 0 first.
- `cfg_valid`  in  1  `cfg_bit` is valid.
- `cfg_ready`  out  1  high only in SHIFT.
- `cfg_active`  out  NBITS  word k occupies bits [6k+5:6k]. Order: top0–4 (k=0–4), bottom0–4 (5–9), left0–3 (10–13), right0–3 (14–17).
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a commit succeeds.
- `err`  out  1  the last load was rejected. Sticky until the next accepted `start` or `clear`.
- `err_idx`  out  5  index k of the first faulty word.
- `err_code`  out  2  1 = bad side (side code >4), 2 = bad index, 3 = self-loop.

## Operation
- FSM states: IDLE, SHIFT, CHECK, COMMIT.
- IDLE → SHIFT on `start`. If `start` and `clear` are both high, `start` wins and `clear` is ignored.
- Accepting `start` clears `err`, `err_idx` and `err_code`, and resets the bit counter (7 bits) to 0.
- SHIFT: each cycle with `cfg_valid && cfg_ready` writes `cfg_bit` into shadow bit [cnt] and increments cnt. When the bit at cnt = 107 is accepted, the state moves to CHECK. Cycles with `cfg_valid` low stall without limit.
- CHECK: one word per cycle, k = 0..17 in order, using combinational checker rules:
  - side code 5–7 → code 1 (bad side).
  - side 1 or 3 with index >4, or side 2 or 4 with index >3 → code 2 (bad index).
  - side equals the word's own side and index equals its own index (e.g. top2 = 6'b010_001) → code 3 (self-loop).
  - side 0 → always legal; the index field is ignored.
- First fault: latch `err`=1, `err_idx`=k and `err_code`, then go to IDLE. `cfg_active` is untouched.
- k = 17 passes → COMMIT.
- COMMIT: `cfg_active` ← shadow and `done` ← 1 (registered), then IDLE.
- `clear` in IDLE: `cfg_active` ← 0 and `err` ← 0 on the next edge. `clear` is ignored while busy.
- `start` while busy is ignored. There is no abort; only `rst_n` terminates a load.

## Timing
- Reset values: state IDLE, `cfg_active` all 0, shadow 0, `cfg_ready` 0, `busy` 0, `done` 0, `err` 0, `err_idx` 0, `err_code` 0.
- `rst_n` low mid-load returns to IDLE immediately; `cfg_active` is forced to 0.
- `start` sampled at edge E: SHIFT and `cfg_ready`=1 from E.
- Last bit accepted at edge E0:
  - CHECK runs cycles 1–18.
  - COMMIT is cycle 19.
  - New `cfg_active` and `done`=1 are visible in cycle 20. `busy` drops in cycle 20.
- Minimum load with `cfg_valid` always high: 108 + 19 + 1 cycles from `start` to `done`.
- Fault at word k: `err` is visible in cycle k+2 after E0, together with IDLE.
- `cfg_active` changes only at a COMMIT edge, at a `clear` edge, or on reset. It never shows a partial set.

## Structure
- Package `switchbox_pkg` holds:
  - side-code constants (SIDE_OFF/TOP/RIGHT/BOTTOM/LEFT);
  - error codes;
  - state enum;
  - N_TB, N_LR, W, N_WORDS;
  - a function mapping word index k to (own side, own index).
- Sub-module `switchbox_cfg_check`: combinational. Inputs are the word, own side and own index; outputs are `fault` and `code`. The loader instantiates it once.

## Test plan
- Reset, then load all zeros → `done` in cycle 20 after the last bit, `cfg_active`=0, `err`=0.
- Load word 5 (bottom0) = 6'b011_010 (right3) and word 14 (right0) = 6'b000_001 (top0), all others 0 → `cfg_active`[35:30]=6'b011010, [89:84]=6'b000001.
- After a good commit, load with word 3 = 6'b000_110 → `err`=1, `err_idx`=3, `err_code`=1, `cfg_active` keeps its previous value, no `done`.
- Word 12 (left2) = 6'b100_010 (right4) → `err_code`=2, `err_idx`=12. Word 2 = 6'b010_001 → `err_code`=3, `err_idx`=2.
- Toggle `cfg_valid` randomly during SHIFT and pulse `start`/`clear` while busy → result identical to an unstalled load; the extra pulses have no effect.
- Assert `rst_n` low at bit 50, then release → IDLE, `cfg_active`=0. A fresh full load then commits correctly.
